// File: rtl/seg_pattern_fsm.sv
// String-pattern recogniser: checks each \0-framed string of classified characters against
// a programmable sequence of class-mask segments with min/max repeat counts (greedy, no backtracking).
module seg_pattern_fsm #(
  parameter int SEGMENTS = 3,
  parameter int CNT_W    = 4,
  parameter int CLASS_W  = 14,
  localparam int NSEG_W  = $clog2(SEGMENTS + 1),
  localparam int SEG_W   = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic [CLASS_W-1:0]           cls,
  input  logic                         cfg_load,
  input  logic [SEGMENTS*CLASS_W-1:0]  cfg_mask,
  input  logic [SEGMENTS*CNT_W-1:0]    cfg_min,
  input  logic [SEGMENTS*CNT_W-1:0]    cfg_max,
  input  logic [NSEG_W-1:0]            cfg_nseg,
  input  logic                         cfg_shared,
  output logic                         match,
  output logic                         mismatch,
  output logic                         busy,
  output logic [SEG_W-1:0]             seg_idx,
  output logic [CNT_W-1:0]             cnt
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  localparam int ACC_N = 2 ** (SEG_W + 1);

  state_t             state_reg, state_next;
  logic [SEG_W-1:0]   seg_reg, seg_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               match_reg, match_next;
  logic               mismatch_reg, mismatch_next;
  logic               busy_reg, busy_next;

  logic [CLASS_W-1:0] mask_reg [SEGMENTS];
  logic [CNT_W-1:0]   min_reg  [SEGMENTS];
  logic [CNT_W-1:0]   max_reg  [SEGMENTS];
  logic [NSEG_W-1:0]  nseg_reg;
  logic               shared_reg;

  logic [CNT_W-1:0]   min_eff  [SEGMENTS];
  logic [CNT_W-1:0]   max_eff  [SEGMENTS];
  logic [ACC_N-1:0]   acc;
  logic [SEG_W-1:0]   last_seg;
  logic [SEG_W:0]     seg_ext, seg_ext_inc;
  logic               cfg_take;
  logic               is_nul;

  assign cfg_take = cfg_load && (state_reg == IDLE);
  assign is_nul   = cls[0];

  // Per-segment config storage and normalisation; raw values are kept, fix-ups applied on read.
  // acc is padded to a power of two so seg+1 can be indexed without range concerns.
  genvar gi;
  generate
    for (gi = 0; gi < ACC_N; gi++) begin : g_seg
      if (gi < SEGMENTS) begin : g_act
        always_ff @(posedge clk) begin
          if (rst) begin
            mask_reg[gi] <= '0;
            min_reg[gi]  <= '0;
            max_reg[gi]  <= '0;
          end else if (cfg_take) begin
            mask_reg[gi] <= cfg_mask[gi*CLASS_W +: CLASS_W];
            min_reg[gi]  <= cfg_min[gi*CNT_W +: CNT_W];
            max_reg[gi]  <= cfg_max[gi*CNT_W +: CNT_W];
          end
        end
        assign min_eff[gi] = (min_reg[gi] == '0) ? CNT_W'(1) : min_reg[gi];
        assign max_eff[gi] = (max_reg[gi] < min_eff[gi]) ? min_eff[gi] : max_reg[gi];
        // Bit 0 (\0) is excluded so the delimiter never counts as a segment character.
        assign acc[gi] = |(cls[CLASS_W-1:1] & mask_reg[gi][CLASS_W-1:1]);
      end else begin : g_pad
        assign acc[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      nseg_reg   <= '0;
      shared_reg <= 1'b0;
    end else if (cfg_take) begin
      nseg_reg   <= cfg_nseg;
      shared_reg <= cfg_shared;
    end
  end

  always_comb begin
    if (nseg_reg == '0)
      last_seg = '0;
    else if (nseg_reg > NSEG_W'(SEGMENTS))
      last_seg = SEG_W'(SEGMENTS - 1);
    else
      last_seg = SEG_W'(nseg_reg - NSEG_W'(1));
  end

  assign seg_ext     = {1'b0, seg_reg};
  assign seg_ext_inc = seg_ext + (SEG_W+1)'(1);

  always_comb begin
    state_next    = state_reg;
    seg_next      = seg_reg;
    cnt_next      = cnt_reg;
    match_next    = 1'b0;
    mismatch_next = 1'b0;
    if (valid) begin
      case (state_reg)
        IDLE: begin
          if (is_nul) begin
            state_next = RUN;
            seg_next   = '0;
            cnt_next   = '0;
          end
        end
        RUN: begin
          if (is_nul) begin
            if ((seg_reg == last_seg) && (cnt_reg >= min_eff[seg_reg]))
              match_next = 1'b1;
            else
              mismatch_next = 1'b1;
            state_next = shared_reg ? RUN : IDLE;
            seg_next   = '0;
            cnt_next   = '0;
          end else if ((cnt_reg < max_eff[seg_reg]) && acc[seg_ext]) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end else if ((seg_reg < last_seg) && (cnt_reg >= min_eff[seg_reg]) && acc[seg_ext_inc]) begin
            seg_next = seg_reg + SEG_W'(1);
            cnt_next = CNT_W'(1);
          end else begin
            state_next = ERR;
          end
        end
        ERR: begin
          if (is_nul) begin
            mismatch_next = 1'b1;
            state_next    = shared_reg ? RUN : IDLE;
            seg_next      = '0;
            cnt_next      = '0;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      seg_reg      <= '0;
      cnt_reg      <= '0;
      match_reg    <= 1'b0;
      mismatch_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      seg_reg      <= seg_next;
      cnt_reg      <= cnt_next;
      match_reg    <= match_next;
      mismatch_reg <= mismatch_next;
      busy_reg     <= busy_next;
    end
  end

  assign match    = match_reg;
  assign mismatch = mismatch_reg;
  assign busy     = busy_reg;
  assign seg_idx  = seg_reg;
  assign cnt      = cnt_reg;

endmodule

// File: doc/seg_pattern_fsm.md
# seg_pattern_fsm

Parametrised string-pattern recogniser for the character-classifier pipeline. It consumes classified bytes framed by `\0` delimiters. It checks each string against a run-time programmable sequence of up to `SEGMENTS` segments, where each segment is a character-class mask plus a min/max repeat count. It emits a one-cycle match or mismatch verdict per string. It replaces the per-variant hard-coded recogniser: the pattern becomes configuration, not RTL.

## Interface

Parameters:
- `SEGMENTS`, default 3: maximum number of pattern segments.
- `CNT_W`, default 4: width of the repeat counters and of the min/max fields.
- `CLASS_W`, default 14: width of the class vector.

Class vector bit order:
- 0 start_stop, 1 small_letter, 2 capital_letter, 3 number, 4 hex_digit
- 5 punctuation_basic, 6 punctuation_finance, 7 parentheses, 8 curly_braces
- 9 math_symbol, 10 whitespace, 11 vowel, 12 consonant, 13 other

Ports:
- `clk`  in  1  clock. Everything is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `valid`  in  1  `cls` holds one classified character this cycle.
- `cls`  in  CLASS_W  class flags of the current character.
- `cfg_load`  in  1  latch the configuration inputs. Honoured only in IDLE.
- `cfg_mask`  in  SEGMENTS*CLASS_W  class mask of segment i, at slice [i*CLASS_W +: CLASS_W].
- `cfg_min`  in  SEGMENTS*CNT_W  minimum repeats of segment i. A value of 0 is treated as 1.
- `cfg_max`  in  SEGMENTS*CNT_W  maximum repeats of segment i. If it is below min, min is used.
- `cfg_nseg`  in  clog2(SEGMENTS+1)  number of active segments. 0 is treated as 1; values above SEGMENTS are clamped to SEGMENTS.
- `cfg_shared`  in  1  when 1, a terminating `\0` also starts the next string.
- `match`  out  1  one-cycle pulse: the string satisfied the pattern.
- `mismatch`  out  1  one-cycle pulse: the string failed.
- `busy`  out  1  state is not IDLE.
- `seg_idx`  out  clog2(SEGMENTS)  current segment.
- `cnt`  out  CNT_W  characters accepted in the current segment.

## Operation

- Configuration is held in internal registers, all zero after reset (with zero masks, nothing matches).
- `cfg_load` in any state other than IDLE is ignored.
- Segment i "accepts" a character when `|(cls & mask_i)` is true. Bit 0 is always removed from the masks, so `\0` never matches a segment.
- `last` is the final active segment, `nseg - 1`.

States:
- IDLE: on `valid` with `cls[0]`, go to RUN with seg=0, cnt=0. All other characters are dropped.
- RUN, on each `valid`, evaluated in priority order:
  1. `\0` with seg==last and cnt ≥ min[seg]: pulse `match`.
  2. `\0` otherwise: pulse `mismatch`.
  3. After case 1 or 2: go to IDLE, or re-enter RUN with seg=0, cnt=0 if `cfg_shared`=1.
  4. cnt < max[seg] and seg accepts: stay, cnt+1.
  5. seg < last, cnt ≥ min[seg], and seg+1 accepts: seg+1, cnt=1.
  6. Otherwise: go to ERR, no pulse.
- ERR: ignore characters until `\0`, then pulse `mismatch`. Next state is IDLE, or RUN with seg=0, cnt=0 if `cfg_shared`=1.

Rules:
- Greedy, no backtracking: staying in a segment (rule 4) beats advancing (rule 5). A pattern that needs backtracking is reported as a mismatch; this is intended.
- An empty string (`\0\0`) is a mismatch because cnt=0 < min.
- cnt never exceeds max[seg] ≤ 2^CNT_W−1, so there is no wrap-around.

## Timing

- Reset: state IDLE; seg_idx, cnt, match, mismatch, busy all 0; config registers 0. Reset mid-string abandons the string with no verdict pulse.
- Every output is registered. A verdict pulses in the cycle after the `valid` cycle that carried the terminating `\0`, and lasts exactly one cycle.
- Back-to-back `valid` every cycle is supported, with no stalls.
- `valid`=0 cycles hold all state and deassert the pulses.
- seg_idx and cnt reflect the character accepted in the previous cycle.
- `cfg_load` and `valid` asserted together in IDLE: the configuration latches. The character is evaluated against the old configuration; the new one applies from the next character.

## Test plan

Common configuration: nseg=3; seg0 = number, 3..5; seg1 = math_symbol, 1..1; seg2 = capital_letter, 1..4; shared=0.

- Stream `\0 1 2 3 + A B \0`: one `match` pulse one cycle after the final `\0`. `busy` falls in the same cycle. `mismatch` never rises.
- `\0 1 2 + A \0` (seg0 short): RUN goes to ERR on `+`; `mismatch` pulses after `\0`.
- `\0 1 2 3 4 5 6 + A \0` (exceeds max=5): ERR on `6`, then `mismatch`. `cnt` reads 5 before the error and never wraps.
- shared=1, stream `\0 1 2 3 + A \0 9 9 9 - B C \0`: two `match` pulses. The middle `\0` serves as both terminator and start, and the second string returns to IDLE-free RUN.
- Assert `rst` after `\0 1 2`, then send `3 + A \0`: no pulses. The block waits in IDLE and starts on the final `\0` as a new string.
- `cfg_load` while busy (nseg=1, mask=other) with string `\0 1 2 3 + A \0`: the load is ignored and `match` still pulses. A later reload in IDLE takes effect.
